// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - MIPS fetch stage: program counter, next-PC selection and IF/ID register
module fetch_pc #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_f,
  input  logic [31:0] instr_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic        exc_adel_d
);

  localparam logic [32:0] IM_LO = {1'b0, IM_BASE};
  localparam logic [32:0] IM_HI = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  logic [31:0] pc_q;
  logic [31:0] next_pc;
  logic [31:0] fetch_word;
  logic        legal;

  assign pc_f = pc_q;

  // 33-bit compare keeps the end-of-memory bound from wrapping at the top of the address space
  always_comb begin
    legal = (pc_q[1:0] == 2'b00)
         && ({1'b0, pc_q} >= IM_LO)
         && ({1'b0, pc_q} <  IM_HI);
  end

  always_comb begin
    next_pc    = redirect_valid ? redirect_pc : pc_q + 32'd4;
    fetch_word = legal ? instr_f : 32'h0;
  end

  // Stall drops any concurrent redirect; the branch re-asserts it once D is released
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= PC_RESET;
    end else if (!stall) begin
      pc_q <= next_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_d    <= 32'h0;
      pc_d       <= 32'h0;
      pc8_d      <= 32'h0;
      valid_d    <= 1'b0;
      exc_adel_d <= 1'b0;
    end else if (flush) begin
      instr_d    <= 32'h0;
      pc_d       <= 32'h0;
      pc8_d      <= 32'h0;
      valid_d    <= 1'b0;
      exc_adel_d <= 1'b0;
    end else if (!stall) begin
      instr_d    <= fetch_word;
      pc_d       <= pc_q;
      pc8_d      <= pc_q + 32'd8;
      valid_d    <= 1'b1;
      exc_adel_d <= !legal;
    end
  end

endmodule

// File: tb/tb_fetch_pc.sv
// tb/tb_fetch_pc.sv - self-checking bench for fetch_pc: vector table, corner sequences, random vs model
module tb_fetch_pc;

  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam int          IM_WORDS = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc_f, instr_f, instr_d, pc_d, pc8_d;
  logic        valid_d, exc_adel_d;

  int total = 0;
  int bad   = 0;

  fetch_pc dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc_f(pc_f), .instr_f(instr_f), .instr_d(instr_d), .pc_d(pc_d),
    .pc8_d(pc8_d), .valid_d(valid_d), .exc_adel_d(exc_adel_d)
  );

  always #5 clk = ~clk;

  // Memory contents: tag bits plus word index, so every legal word is nonzero and distinct
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - IM_BASE;
    return 32'hC000_0000 | (off >> 2);
  endfunction

  assign instr_f = mem_word(pc_f);

  // Reference model: architectural state as plain variables, legality from integer ranges
  logic [31:0] m_pc, m_instr, m_pcd, m_pc8;
  logic        m_valid, m_exc;

  function automatic bit m_legal(input logic [31:0] a);
    longint u;
    u = longint'(a);
    return (u % 4 == 0) && (u >= longint'(IM_BASE)) && (u < longint'(IM_BASE) + 4 * IM_WORDS);
  endfunction

  task automatic m_reset();
    m_pc = 32'h0000_3000; m_instr = 0; m_pcd = 0; m_pc8 = 0; m_valid = 0; m_exc = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic s, input logic f, input logic rv, input logic [31:0] rp);
    stall = s; flush = f; redirect_valid = rv; redirect_pc = rp;
    if (f) begin
      m_instr = 0; m_pcd = 0; m_pc8 = 0; m_valid = 0; m_exc = 0;
    end else if (!s) begin
      m_instr = m_legal(m_pc) ? mem_word(m_pc) : 32'h0;
      m_pcd   = m_pc;
      m_pc8   = m_pc + 32'd8;
      m_valid = 1;
      m_exc   = !m_legal(m_pc);
    end
    if (!s) m_pc = rv ? rp : m_pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " pc_f"},    pc_f,       m_pc);
    chk({tag, " instr_d"}, instr_d,    m_instr);
    chk({tag, " pc_d"},    pc_d,       m_pcd);
    chk({tag, " pc8_d"},   pc8_d,      m_pc8);
    chk({tag, " valid_d"}, 32'(valid_d),    32'(m_valid));
    chk({tag, " exc"},     32'(exc_adel_d), 32'(m_exc));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " pc_f"},    pc_f,    32'h0000_3000);
    chk({tag, " instr_d"}, instr_d, 32'h0);
    chk({tag, " pc_d"},    pc_d,    32'h0);
    chk({tag, " pc8_d"},   pc8_d,   32'h0);
    chk({tag, " valid_d"}, 32'(valid_d),    32'h0);
    chk({tag, " exc"},     32'(exc_adel_d), 32'h0);
  endtask

  typedef struct {
    logic        s, f, rv;
    logic [31:0] rp;
    logic [31:0] e_pcf, e_pcd, e_instr;
    logic        e_valid, e_exc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic f, input logic rv, input logic [31:0] rp,
                     input logic [31:0] e_pcf, input logic [31:0] e_pcd, input logic [31:0] e_instr,
                     input logic e_valid, input logic e_exc);
    vec_t v;
    v.s = s; v.f = f; v.rv = rv; v.rp = rp;
    v.e_pcf = e_pcf; v.e_pcd = e_pcd; v.e_instr = e_instr; v.e_valid = e_valid; v.e_exc = e_exc;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 0; stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0;
    m_reset();

    //   s f rv rp             pc_f           pc_d           instr_d        v  exc
    add(0, 0, 0, 32'h0,        32'h0000_3004, 32'h0000_3000, 32'hC000_0000, 1, 0);
    add(0, 0, 0, 32'h0,        32'h0000_3008, 32'h0000_3004, 32'hC000_0001, 1, 0);
    add(1, 0, 0, 32'h0,        32'h0000_3008, 32'h0000_3004, 32'hC000_0001, 1, 0);
    add(1, 0, 0, 32'h0,        32'h0000_3008, 32'h0000_3004, 32'hC000_0001, 1, 0);
    add(0, 0, 0, 32'h0,        32'h0000_300C, 32'h0000_3008, 32'hC000_0002, 1, 0);
    add(0, 0, 0, 32'h0,        32'h0000_3010, 32'h0000_300C, 32'hC000_0003, 1, 0);
    add(0, 0, 1, 32'h0000_3400, 32'h0000_3400, 32'h0000_3010, 32'hC000_0004, 1, 0);
    add(1, 0, 1, 32'h0000_3400, 32'h0000_3400, 32'h0000_3010, 32'hC000_0004, 1, 0);
    add(0, 0, 1, 32'h0000_3020, 32'h0000_3020, 32'h0000_3400, 32'hC000_0100, 1, 0);
    add(1, 1, 0, 32'h0,        32'h0000_3020, 32'h0000_0000, 32'h0000_0000, 0, 0);
    add(0, 0, 1, 32'h0000_3002, 32'h0000_3002, 32'h0000_3020, 32'hC000_0008, 1, 0);
    add(0, 0, 1, 32'h0000_7000, 32'h0000_7000, 32'h0000_3002, 32'h0000_0000, 1, 1);
    add(0, 0, 1, 32'h0000_2FFC, 32'h0000_2FFC, 32'h0000_7000, 32'h0000_0000, 1, 1);
    add(0, 0, 1, 32'h0000_6FFC, 32'h0000_6FFC, 32'h0000_2FFC, 32'h0000_0000, 1, 1);
    add(0, 0, 1, 32'h0000_3040, 32'h0000_3040, 32'h0000_6FFC, 32'hC000_0FFF, 1, 0);
    add(0, 1, 0, 32'h0,        32'h0000_3044, 32'h0000_0000, 32'h0000_0000, 0, 0);
    add(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_3044, 32'hC000_0011, 1, 0);
    add(0, 0, 0, 32'h0,        32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 1, 1);
    add(0, 0, 1, 32'h0000_3040, 32'h0000_3040, 32'h0000_0000, 32'h0000_0000, 1, 1);

    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    reset = 1;

    foreach (vecs[i]) begin
      string tag;
      logic [31:0] e_pc8;
      tag = $sformatf("vec%0d", i);
      cycle(vecs[i].s, vecs[i].f, vecs[i].rv, vecs[i].rp);
      e_pc8 = vecs[i].e_valid ? vecs[i].e_pcd + 32'd8 : 32'h0;
      chk({tag, " pc_f"},    pc_f,    vecs[i].e_pcf);
      chk({tag, " pc_d"},    pc_d,    vecs[i].e_pcd);
      chk({tag, " instr_d"}, instr_d, vecs[i].e_instr);
      chk({tag, " pc8_d"},   pc8_d,   e_pc8);
      chk({tag, " valid_d"}, 32'(valid_d),    32'(vecs[i].e_valid));
      chk({tag, " exc"},     32'(exc_adel_d), 32'(vecs[i].e_exc));
    end

    // Asynchronous reset mid-cycle at pc_f=0x3040: outputs must clear before any edge
    stall = 0; flush = 0; redirect_valid = 0;
    #3;
    reset = 0;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clk);
    #1;
    chk_reset_vals("held_rst");
    #2;
    reset = 1;
    m_reset();
    cycle(0, 0, 0, 32'h0);
    chk("restart pc_f", pc_f, 32'h0000_3004);
    chk("restart pc_d", pc_d, 32'h0000_3000);
    chk("restart valid", 32'(valid_d), 32'h1);
    chk_model("restart");

    for (int n = 0; n < 400; n++) begin
      logic s, f, rv;
      logic [31:0] rp;
      s  = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 7) == 0);
      rv = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0:       rp = (IM_BASE + ($urandom_range(0, 16383) & 32'hFFFF_FFFC)) | 32'd2;
        1:       rp = $urandom();
        2:       rp = IM_BASE + 32'(4 * IM_WORDS) - 32'($urandom_range(0, 1) * 4);
        default: rp = IM_BASE + 32'(4 * $urandom_range(0, IM_WORDS - 1));
      endcase
      cycle(s, f, rv, rp);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
